// File: rtl/seg_capture.sv
// seg_capture: sample a scanned six-digit seven-segment bus, debounce each digit, decode to BCD and publish hh:mm:ss frames
//
// Ports:
//   clk           system clock, same domain as the scanner
//   rstn          asynchronous reset, active-high despite the name
//   seg_sel[5:0]  digit select, active-low one-hot, bit i = digit i (0 = seconds units)
//   seg_data[7:0] segments, active-low, bit7 = dp, bits[6:0] = g..a
//   digits[23:0]  published BCD, digits[4i+3:4i] = digit i
//   dp[5:0]       published decimal points, active-high
//   frame_strobe  one-cycle pulse when digits/dp update
//   frame_valid   high after a publish, low after reset or timeout
//   code_err      last published frame held an undecodable pattern
module seg_capture #(
    parameter int STABLE_CNT = 4,
    parameter int TIMEOUT    = 1048576
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [5:0]  seg_sel,
    input  logic [7:0]  seg_data,
    output logic [23:0] digits,
    output logic [5:0]  dp,
    output logic        frame_strobe,
    output logic        frame_valid,
    output logic        code_err
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [7:0] SC_MAX = 8'(STABLE_CNT);
    localparam logic [7:0] SC_CAP = 8'(STABLE_CNT - 1);
    localparam logic [TW-1:0] T_END = TW'(TIMEOUT - 1);

    logic [13:0]   r;
    logic [7:0]    scnt, scnt_nx;
    logic          taken;
    logic [5:0]    seen;
    logic [23:0]   sh_dig;
    logic [5:0]    sh_dp, sh_err;
    logic [TW-1:0] tcnt;
    logic          same, one_sel, cap, pub;
    logic [5:0]    zsel;
    logic [4:0]    dec;

    // {err, nibble}; anything outside the ten digit glyphs decodes to F with error
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h40:   decode = 5'h00;
            7'h79:   decode = 5'h01;
            7'h24:   decode = 5'h02;
            7'h30:   decode = 5'h03;
            7'h19:   decode = 5'h04;
            7'h12:   decode = 5'h05;
            7'h02:   decode = 5'h06;
            7'h78:   decode = 5'h07;
            7'h00:   decode = 5'h08;
            7'h10:   decode = 5'h09;
            default: decode = 5'h1F;
        endcase
    endfunction

    // The sample about to enter r is compared with the one already in r, so
    // scnt_nx counts identical samples minus one and the capture lands on the
    // edge that registers the STABLE_CNT-th identical sample.
    always_comb begin
        same    = ({seg_sel, seg_data} == r);
        scnt_nx = !same ? 8'd0 : (scnt == SC_MAX ? scnt : scnt + 8'd1);
        zsel    = ~r[13:8];
        one_sel = (zsel != 6'd0) && ((zsel & (zsel - 6'd1)) == 6'd0);
        cap     = same && (scnt_nx == SC_CAP) && !taken && one_sel;
        pub     = (seen == 6'h3F);
        dec     = decode(r[6:0]);
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r            <= 14'h3FFF;
            scnt         <= 8'd0;
            taken        <= 1'b0;
            seen         <= 6'd0;
            sh_dig       <= 24'd0;
            sh_dp        <= 6'd0;
            sh_err       <= 6'd0;
            tcnt         <= '0;
            digits       <= 24'd0;
            dp           <= 6'd0;
            frame_strobe <= 1'b0;
            frame_valid  <= 1'b0;
            code_err     <= 1'b0;
        end else begin
            r     <= {seg_sel, seg_data};
            scnt  <= scnt_nx;
            taken <= same && (taken || cap);
            for (int k = 0; k < 6; k++) begin
                if (cap && zsel[k]) begin
                    sh_dig[4*k +: 4] <= dec[3:0];
                    sh_dp[k]         <= ~r[7];
                    sh_err[k]        <= dec[4];
                end
            end
            // publish reads the pre-capture shadow; a same-cycle capture survives in seen
            seen         <= (pub ? 6'h00 : seen) | (cap ? zsel : 6'h00);
            frame_strobe <= pub;
            if (pub) begin
                digits   <= sh_dig;
                dp       <= sh_dp;
                code_err <= |sh_err;
            end
            tcnt        <= pub ? '0 : (tcnt == T_END ? tcnt : tcnt + 1'b1);
            frame_valid <= pub ? 1'b1 : (tcnt == T_END ? 1'b0 : frame_valid);
        end
    end
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed vector and corner-sequence bench for seg_capture
module tb_seg_capture;
    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [5:0]  seg_sel = 6'h3F;
    logic [7:0]  seg_data = 8'hFF;
    logic [23:0] digits;
    logic [5:0]  dp;
    logic        frame_strobe, frame_valid, code_err;

    seg_capture #(.STABLE_CNT(4), .TIMEOUT(64)) dut (
        .clk(clk), .rstn(rstn), .seg_sel(seg_sel), .seg_data(seg_data),
        .digits(digits), .dp(dp), .frame_strobe(frame_strobe),
        .frame_valid(frame_valid), .code_err(code_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int strobes = 0;

    always @(posedge clk) begin
        #2;
        if (frame_strobe === 1'b1) strobes++;
    end

    typedef struct {
        logic [23:0] val;
        logic [5:0]  dpm;
        logic        ghost;
        logic [23:0] exp_dig;
        logic [5:0]  exp_dp;
        logic        exp_err;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    task automatic set_digit(input int i, input logic [3:0] n, input logic dpb);
        logic [5:0] one;
        one = 6'b1;
        seg_sel  = ~(one << i);
        seg_data = {~dpb, seg7(n)};
    endtask

    task automatic show(input int i, input logic [3:0] n, input logic dpb, input int cyc);
        set_digit(i, n, dpb);
        repeat (cyc) @(negedge clk);
    endtask

    task automatic scan(input logic [23:0] val, input logic [5:0] dpm, input logic ghost);
        for (int i = 0; i < 6; i++) begin
            if (ghost) begin
                seg_data = {~dpm[i], seg7(val[4*i +: 4])};
                repeat (3) @(negedge clk);
            end
            show(i, val[4*i +: 4], dpm[i], 10);
        end
    endtask

    initial begin
        int s0;
        vt[0] = '{24'h123456, 6'b010100, 1'b0, 24'h123456, 6'b010100, 1'b0};
        vt[1] = '{24'h987012, 6'b000000, 1'b1, 24'h987012, 6'b000000, 1'b0};
        vt[2] = '{24'h12F456, 6'b100001, 1'b0, 24'h12F456, 6'b100001, 1'b1};
        vt[3] = '{24'h234559, 6'b000000, 1'b1, 24'h234559, 6'b000000, 1'b0};
        vt[4] = '{24'h000000, 6'b111111, 1'b0, 24'h000000, 6'b111111, 1'b0};
        vt[5] = '{24'h888888, 6'b001000, 1'b1, 24'h888888, 6'b001000, 1'b0};
        vt[6] = '{24'h1F0F00, 6'b000000, 1'b0, 24'h1F0F00, 6'b000000, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_digits", 32'(digits), 0);
        chk("rst_dp", 32'(dp), 0);
        chk("rst_strobe", 32'(frame_strobe), 0);
        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_err", 32'(code_err), 0);
        rstn = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            s0 = strobes;
            scan(vt[v].val, vt[v].dpm, vt[v].ghost);
            chk($sformatf("v%0d_strobes", v), 32'(strobes - s0), 1);
            chk($sformatf("v%0d_digits", v), 32'(digits), 32'(vt[v].exp_dig));
            chk($sformatf("v%0d_dp", v), 32'(dp), 32'(vt[v].exp_dp));
            chk($sformatf("v%0d_err", v), 32'(code_err), 32'(vt[v].exp_err));
            chk($sformatf("v%0d_valid", v), 32'(frame_valid), 1);
        end

        // short glitch, blanking and multi-select mid-scan, then capture latency
        s0 = strobes;
        for (int i = 0; i < 3; i++) show(i, 4'(i + 1), 1'b0, 10);
        seg_sel = 6'h3F;
        repeat (20) @(negedge clk);
        seg_sel = 6'h3C;
        seg_data = {1'b1, seg7(4'd8)};
        repeat (20) @(negedge clk);
        for (int i = 3; i < 5; i++) show(i, 4'(i + 1), 1'b0, 10);
        show(5, 4'd6, 1'b0, 3);
        seg_sel = 6'h3F;
        repeat (5) @(negedge clk);
        chk("glitch_blank_nostrobe", 32'(strobes - s0), 0);
        set_digit(5, 4'd6, 1'b0);
        repeat (4) @(negedge clk);
        chk("lat_strobe_early", 32'(frame_strobe), 0);
        @(negedge clk);
        chk("lat_strobe", 32'(frame_strobe), 1);
        chk("lat_digits", 32'(digits), 32'h654321);
        chk("lat_valid", 32'(frame_valid), 1);
        chk("lat_err", 32'(code_err), 0);
        seg_sel = 6'h3F;
        @(negedge clk);
        chk("lat_strobe_width", 32'(frame_strobe), 0);

        // timeout: valid falls 64 cycles after the strobe, digits hold
        repeat (62) @(negedge clk);
        chk("to_valid_63", 32'(frame_valid), 1);
        @(negedge clk);
        chk("to_valid_64", 32'(frame_valid), 0);
        chk("to_digits_hold", 32'(digits), 32'h654321);
        chk("to_total_strobes", 32'(strobes - s0), 1);

        // reset mid-frame after a frame with an error
        scan(24'h7F7777, 6'b000001, 1'b0);
        chk("pre_rst_err", 32'(code_err), 1);
        for (int i = 0; i < 4; i++) show(i, 4'd9, 1'b1, 10);
        rstn = 1'b1;
        #1;
        chk("arst_digits", 32'(digits), 0);
        chk("arst_dp", 32'(dp), 0);
        chk("arst_valid", 32'(frame_valid), 0);
        chk("arst_err", 32'(code_err), 0);
        chk("arst_strobe", 32'(frame_strobe), 0);
        @(negedge clk);
        rstn = 1'b0;
        s0 = strobes;
        show(4, 4'd4, 1'b0, 10);
        show(5, 4'd2, 1'b0, 10);
        chk("post_rst_nostrobe", 32'(strobes - s0), 0);
        chk("post_rst_valid", 32'(frame_valid), 0);
        show(0, 4'd3, 1'b0, 10);
        show(1, 4'd1, 1'b0, 10);
        show(2, 4'd8, 1'b1, 10);
        show(3, 4'd6, 1'b0, 10);
        chk("post_rst_strobe", 32'(strobes - s0), 1);
        chk("post_rst_digits", 32'(digits), 32'h246813);
        chk("post_rst_dp", 32'(dp), 32'h04);
        chk("post_rst_valid2", 32'(frame_valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg_capture.md
# seg_capture

Receive-side counterpart of the display scanner. It samples the multiplexed six-digit seven-segment bus (`seg_sel`/`seg_data`) and rejects transient patterns seen during digit switching. It decodes each stable digit back to BCD and republishes a complete hh:mm:ss frame with a strobe. It is used for self-check of the clock datapath and for remote monitoring of any scanned display in the design.

## Interface
Parameters:
- `STABLE_CNT`, 4: consecutive identical registered samples required before a digit is accepted; legal range 2..255.
- `TIMEOUT`, 1048576: cycles without a published frame before `frame_valid` drops; minimum 16.

Ports:
- `clk`  in  1  system clock, same domain as the scanner.
- `rstn`  in  1  asynchronous, active-high reset; one clock.
- `seg_sel`  in  6  digit select, active-low one-hot; bit i = digit i (0 = seconds units, 5 = hours tens).
- `seg_data`  in  8  segments, active-low; bit7 = dp, bits[6:0] = g..a.
- `digits`  out  24  published BCD; `digits[4i+3:4i]` = digit i.
- `dp`  out  6  published decimal points, active-high (1 = `seg_data[7]` was 0).
- `frame_strobe`  out  1  one-cycle pulse when `digits`/`dp` update.
- `frame_valid`  out  1  high after a publish; low after reset or timeout.
- `code_err`  out  1  high when the last published frame held an undecodable pattern.

## Operation
- Input stage: `{seg_sel, seg_data}` is registered once into `r`, then compared with the previous `r`.
- Stability counter `scnt` (8 bit):
  - Cleared when `r` changes; otherwise increments, saturating at `STABLE_CNT`.
  - A per-dwell `taken` flag clears on any change.
- Capture condition: `scnt` reaches `STABLE_CNT-1`, `taken`=0, and `r.sel` has exactly one zero bit. On capture:
  - Write the decoded nibble, dp and error bit into shadow slot i.
  - Set `seen[i]` and set `taken`.
  - A repeated capture of the same digit before frame completion overwrites the slot (latest wins).
- Ignored select values (no capture, no error):
  - `sel`=6'h3F (blanking).
  - Multi-zero `sel`.
- Decode of bits[6:0], active-low:
  - 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h.
  - Any other pattern gives nibble F and slot error bit = 1.
- Publish when `seen`=6'h3F:
  - Copy the shadow to `digits`/`dp`.
  - `code_err` = OR of the slot error bits.
  - Pulse `frame_strobe`, set `frame_valid`, clear `seen`.
- Timeout:
  - `tcnt` increments every cycle and clears on publish.
  - At `TIMEOUT-1`, `frame_valid` goes to 0 and `tcnt` holds.
  - `digits`, `dp` and `code_err` hold their values.
- Capture and publish in the same cycle: publish uses the pre-capture shadow and clears `seen`, then sets only the new `seen[i]`. No capture is lost.

## Timing
- Reset values: `digits`=0, `dp`=0, `frame_strobe`=0, `frame_valid`=0, `code_err`=0. Internal reset values: `seen`=0, `scnt`=0, `tcnt`=0, `taken`=0.
- Reset mid-frame discards the shadow; the first frame after reset needs all six digits captured again.
- Capture latency:
  - Input held from edge n is in `r` after edge n.
  - Shadow is written at edge n+STABLE_CNT-1.
- Publish occurs one edge after the sixth capture.
  - `frame_strobe` is high for exactly that one cycle.
  - `digits` is valid in the same cycle as `frame_strobe`.
- A glitch shorter than `STABLE_CNT` samples never captures. A dwell of any length captures exactly once.

## Test plan
- Clean scan with `STABLE_CNT`=4:
  - Stimulus: cycle digits 0..5 showing 12:34:56 with dp on digits 2 and 4, dwell 10 cycles each.
  - Required: `frame_strobe` pulses once per scan.
  - Required: `digits`=24'h123456 with the digit 0 nibble = 6, i.e. `{1,2,3,4,5,6}` from digit 5 down to digit 0.
  - Required: `dp`=6'b010100, `frame_valid`=1, `code_err`=0.
- Ghosting:
  - Stimulus: insert 3-cycle transient patterns (old sel, new data) between dwells.
  - Required: decoded values are unchanged; no extra captures.
- Invalid pattern:
  - Stimulus: digit 3 shows 7Fh.
  - Required: `digits[15:12]`=F and `code_err`=1.
  - Required: the next clean frame returns `code_err`=0.
- Blanking and multi-select:
  - Stimulus: `sel`=3Fh and `sel`=3Ch for 20 cycles, mid-scan.
  - Required: no capture; `seen` is unaffected; the frame completes normally afterwards.
- Timeout with `TIMEOUT`=64:
  - Stimulus: stop the scan after one frame.
  - Required: `frame_valid` falls exactly 64 cycles after `frame_strobe`; `digits` holds.
- Reset:
  - Stimulus: assert `rstn` after 4 of 6 captures.
  - Required: all outputs return to 0 immediately.
  - Required: the first strobe after reset comes only after six fresh captures.
